// File: rtl/menu_pkg.sv
// Shared types and constants for the menu/return sequencer.
// Holds the FSM state encoding, menu option indices, the renderer's
// run-image base code, and small helpers that map a selection onto
// renderer codes and one-hot start vectors.
package menu_pkg;

    localparam int unsigned SEL_W   = 2;
    localparam int unsigned UI_W    = 4;
    localparam int unsigned START_W = 3;

    typedef enum logic [1:0] {
        MENU,
        LAUNCH,
        RUN,
        RETURN
    } menu_state_t;

    localparam logic [SEL_W-1:0] OPT_MANUAL   = 2'd0;
    localparam logic [SEL_W-1:0] OPT_SOLVER   = 2'd1;
    localparam logic [SEL_W-1:0] OPT_GENERATE = 2'd2;

    localparam logic [UI_W-1:0] UI_RUN_BASE = 4'd8;

    // Renderer code shown while a mode owns the display.
    function automatic logic [UI_W-1:0] ui_run_code(input logic [SEL_W-1:0] sel);
        return UI_RUN_BASE | UI_W'(sel);
    endfunction

    // One-hot start vector for the selected mode.
    function automatic logic [START_W-1:0] start_onehot(input logic [SEL_W-1:0] sel);
        logic [START_W-1:0] v;
        v = '0;
        case (sel)
            OPT_MANUAL:   v = 3'b001;
            OPT_SOLVER:   v = 3'b010;
            OPT_GENERATE: v = 3'b100;
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/menu_ctrl_btn_edge.sv
// btn_edge: registered rising-edge detector for one debounced button.
// Ports:
//   clk_in    - system clock
//   reset_in  - synchronous active-high reset
//   level_in  - debounced button level
//   pulse_out - one-cycle pulse, registered, on each 0->1 transition
module btn_edge (
    input  logic clk_in,
    input  logic reset_in,
    input  logic level_in,
    output logic pulse_out
);

    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    // Edge compare against the previous cycle's level.
    always_comb begin
        prev_d  = level_in;
        pulse_d = level_in & ~prev_q;
    end

    // During reset the history tracks the live level, so a button held
    // across reset release is seen as already high and makes no edge.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            prev_q  <= level_in;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: menu/return sequencer for the UI renderer.
// Turns button edges into a frame-synchronised menu selection, launches the
// chosen mode with a one-cycle start pulse and returns to the menu when the
// mode finishes or the user backs out.
// Optional build macro: MENU_AUTO_REPEAT_EN (held up/down auto-repeat).
// Ports:
//   clk_in, reset_in      - clock, synchronous active-high reset
//   btn_up/down/center/back - debounced button levels
//   frame_tick            - one-cycle pulse at start of vertical blank
//   mode_done             - running mode finished (level or pulse)
//   ui_state[3:0]         - renderer state (0..2 menu, 8..10 running)
//   mode_start[2:0]       - one-hot start pulse (manual, solver, generate)
//   active_mode[1:0]      - committed selection
//   running               - a mode owns the display
module menu_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned NUM_OPTS = 3
`ifdef MENU_AUTO_REPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY  = 24'd6_500_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd2_600_000
`endif
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_center,
    input  logic               btn_back,
    input  logic               frame_tick,
    input  logic               mode_done,
    output logic [UI_W-1:0]    ui_state,
    output logic [START_W-1:0] mode_start,
    output logic [SEL_W-1:0]   active_mode,
    output logic               running
);

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_OPTS - 1);

    logic up_e, down_e, center_e, back_e;
    logic rpt_up_c, rpt_down_c;
    logic mv_up_c, mv_down_c;

    menu_state_t        state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   sel_next_q, sel_next_d;
    logic [UI_W-1:0]    ui_state_q, ui_state_d;
    logic [START_W-1:0] mode_start_q, mode_start_d;
    logic               running_q, running_d;

    btn_edge u_edge_up     (.clk_in(clk_in), .reset_in(reset_in), .level_in(btn_up),     .pulse_out(up_e));
    btn_edge u_edge_down   (.clk_in(clk_in), .reset_in(reset_in), .level_in(btn_down),   .pulse_out(down_e));
    btn_edge u_edge_center (.clk_in(clk_in), .reset_in(reset_in), .level_in(btn_center), .pulse_out(center_e));
    btn_edge u_edge_back   (.clk_in(clk_in), .reset_in(reset_in), .level_in(btn_back),   .pulse_out(back_e));

`ifdef MENU_AUTO_REPEAT_EN
    logic [23:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_first_q, rpt_first_d;
    logic        rpt_hold_c, rpt_fire_c;

    // Hold timer: restarts on each real edge, first wait is the longer delay.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire_c  = 1'b0;
        rpt_hold_c  = (state_q == MENU) && (btn_up ^ btn_down);
        if (!rpt_hold_c || up_e || down_e) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_cnt_q == ((rpt_first_q ? REPEAT_DELAY : REPEAT_PERIOD) - 24'd1)) begin
            rpt_fire_c  = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end else begin
            rpt_cnt_d = rpt_cnt_q + 24'd1;
        end
        rpt_up_c   = rpt_fire_c & btn_up;
        rpt_down_c = rpt_fire_c & btn_down;
    end
`else
    always_comb begin
        rpt_up_c   = 1'b0;
        rpt_down_c = 1'b0;
    end
`endif

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_next_d   = sel_next_q;
        ui_state_d   = ui_state_q;
        mode_start_d = '0;
        running_d    = running_q;
        mv_up_c      = up_e | rpt_up_c;
        mv_down_c    = down_e | rpt_down_c;

        case (state_q)
            MENU: begin
                // Pending selection becomes visible only at a frame boundary.
                if (frame_tick) begin
                    sel_d      = sel_next_q;
                    ui_state_d = UI_W'(sel_next_q);
                end
                if (center_e) begin
                    state_d = LAUNCH;
                end else if (mv_up_c && !mv_down_c) begin
                    sel_next_d = (sel_next_q == '0) ? MAX_SEL : sel_next_q - SEL_W'(1);
                end else if (mv_down_c && !mv_up_c) begin
                    sel_next_d = (sel_next_q == MAX_SEL) ? '0 : sel_next_q + SEL_W'(1);
                end
            end
            LAUNCH: begin
                if (frame_tick) begin
                    mode_start_d = start_onehot(sel_q);
                    running_d    = 1'b1;
                    ui_state_d   = ui_run_code(sel_q);
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (mode_done || back_e) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                // Drop any moves made before launch so the menu reopens clean.
                if (frame_tick) begin
                    ui_state_d = UI_W'(sel_q);
                    running_d  = 1'b0;
                    sel_next_d = sel_q;
                    state_d    = MENU;
                end
            end
            default: begin
                state_d = MENU;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= MENU;
            sel_q        <= '0;
            sel_next_q   <= '0;
            ui_state_q   <= '0;
            mode_start_q <= '0;
            running_q    <= 1'b0;
`ifdef MENU_AUTO_REPEAT_EN
            rpt_cnt_q    <= '0;
            rpt_first_q  <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_next_q   <= sel_next_d;
            ui_state_q   <= ui_state_d;
            mode_start_q <= mode_start_d;
            running_q    <= running_d;
`ifdef MENU_AUTO_REPEAT_EN
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_first_q  <= rpt_first_d;
`endif
        end
    end

    assign ui_state    = ui_state_q;
    assign mode_start  = mode_start_q;
    assign active_mode = sel_q;
    assign running     = running_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Bench for menu_ctrl: stimulus queues the expected output vector for every
// change it provokes; a monitor pops one entry per observed output change.
// Vector layout: {ui_state[3:0], running, mode_start[2:0], active_mode[1:0]}.
module tb_menu_ctrl;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       btn_up, btn_down, btn_center, btn_back;
    logic       frame_tick, mode_done;
    logic [3:0] ui_state;
    logic [2:0] mode_start;
    logic [1:0] active_mode;
    logic       running;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic       mon_armed = 1'b0;
    logic [9:0] prev_obs;

    menu_ctrl dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_center  (btn_center),
        .btn_back    (btn_back),
        .frame_tick  (frame_tick),
        .mode_done   (mode_done),
        .ui_state    (ui_state),
        .mode_start  (mode_start),
        .active_mode (active_mode),
        .running     (running)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [9:0] vec(input logic [3:0] ui, input logic run,
                                       input logic [2:0] ms, input logic [1:0] am);
        return {ui, run, ms, am};
    endfunction

    // Monitor: every change of the output vector must match the queue head.
    always @(negedge clk_in) begin
        logic [9:0] cur;
        logic [9:0] exp_v;
        cur = {ui_state, running, mode_start, active_mode};
        if (mon_en) begin
            if (!mon_armed) begin
                prev_obs  = cur;
                mon_armed = 1'b1;
            end else if (cur != prev_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got=%h required=no change", cur);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (cur !== exp_v) begin
                        errors++;
                        $display("FAIL output_change got=%h required=%h", cur, exp_v);
                    end
                end
                prev_obs = cur;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // 0 up, 1 down, 2 center, 3 back
    task automatic press(input int b);
        case (b)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_center = 1'b1;
            default: btn_back = 1'b1;
        endcase
        cyc(2);
        btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0; btn_back = 1'b0;
        cyc(3);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(3);
    endtask

    initial begin
        reset_in = 1'b1;
        btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0; btn_back = 1'b0;
        frame_tick = 1'b0; mode_done = 1'b0;
        cyc(3);
        reset_in = 1'b0;
        cyc(1);
        chk("reset_outputs", {ui_state, running, mode_start, active_mode}, 10'h000);
        mon_en = 1'b1;
        cyc(2);

        // Idle frames: nothing changes.
        repeat (3) tick();
        chk("idle_frames", {ui_state, running, mode_start, active_mode}, 10'h000);

        // Single moves and wrap in both directions.
        press(1); exp_q.push_back(vec(4'd1, 1'b0, 3'b000, 2'd1)); tick();
        press(1); exp_q.push_back(vec(4'd2, 1'b0, 3'b000, 2'd2)); tick();
        press(1); exp_q.push_back(vec(4'd0, 1'b0, 3'b000, 2'd0)); tick();
        press(0); exp_q.push_back(vec(4'd2, 1'b0, 3'b000, 2'd2)); tick();
        press(1); exp_q.push_back(vec(4'd0, 1'b0, 3'b000, 2'd0)); tick();

        // Two moves in one frame commit together.
        press(1); press(1);
        exp_q.push_back(vec(4'd2, 1'b0, 3'b000, 2'd2)); tick();
        press(0); exp_q.push_back(vec(4'd1, 1'b0, 3'b000, 2'd1)); tick();

        // Launch solver; moves during RUN are ignored.
        press(2);
        exp_q.push_back(vec(4'd9, 1'b1, 3'b010, 2'd1));
        exp_q.push_back(vec(4'd9, 1'b1, 3'b000, 2'd1));
        tick();
        press(0); press(1); press(2); tick();
        chk("run_ignores_moves", {ui_state, running, mode_start, active_mode},
            vec(4'd9, 1'b1, 3'b000, 2'd1));

        // Return via mode_done pulse.
        mode_done = 1'b1; cyc(1); mode_done = 1'b0; cyc(2);
        exp_q.push_back(vec(4'd1, 1'b0, 3'b000, 2'd1)); tick();

        // Return via back.
        press(2);
        exp_q.push_back(vec(4'd9, 1'b1, 3'b010, 2'd1));
        exp_q.push_back(vec(4'd9, 1'b1, 3'b000, 2'd1));
        tick();
        press(3);
        exp_q.push_back(vec(4'd1, 1'b0, 3'b000, 2'd1)); tick();

        // mode_done already high on entry ends the run at once.
        mode_done = 1'b1;
        press(2);
        exp_q.push_back(vec(4'd9, 1'b1, 3'b010, 2'd1));
        exp_q.push_back(vec(4'd9, 1'b1, 3'b000, 2'd1));
        tick();
        mode_done = 1'b0;
        exp_q.push_back(vec(4'd1, 1'b0, 3'b000, 2'd1)); tick();

        // Generate mode, then reset in the middle of the run.
        press(1); exp_q.push_back(vec(4'd2, 1'b0, 3'b000, 2'd2)); tick();
        press(2);
        exp_q.push_back(vec(4'd10, 1'b1, 3'b100, 2'd2));
        exp_q.push_back(vec(4'd10, 1'b1, 3'b000, 2'd2));
        tick();
        btn_center = 1'b1;
        cyc(2);
        exp_q.push_back(vec(4'd0, 1'b0, 3'b000, 2'd0));
        reset_in = 1'b1;
        cyc(1);
        chk("reset_mid_run_ui", {6'd0, ui_state}, 10'd0);
        chk("reset_mid_run_running", {9'd0, running}, 10'd0);
        cyc(2);
        reset_in = 1'b0;
        cyc(4);
        tick();
        tick();
        btn_center = 1'b0;
        cyc(3);
        chk("held_center_no_launch", {ui_state, running, mode_start, active_mode}, 10'h000);

        // Menu still works after reset: sel 0 -> up wraps to 2.
        press(0); exp_q.push_back(vec(4'd2, 1'b0, 3'b000, 2'd2)); tick();

        begin
            int budget;
            budget = 100;
            while (exp_q.size() != 0 && budget > 0) begin
                cyc(1);
                budget--;
            end
        end
        chk("queue_drained", 10'(exp_q.size()), 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
